sync_byte_fifo: RTL and testbench
=================================

// Module: sync_byte_fifo
// PURPOSE
//  Single-clock, synchronous FIFO buffering bytes between the USB byte-stream logic and its consumer.
//  Write side pushes on wr, read side pops on rd with a registered data output and a valid strobe.
//  Storage is a simple dual-port RAM (maps to iCE40 EBR); full/empty flags gate both sides.
// PARAMETERS
//  WIDTH   8    data width in bits
//  DEPTH   512  number of entries; must be a power of two (ADDR_W = $clog2(DEPTH))
// PORTS
//  clk    in   1      sole clock; all logic on rising edge
//  rst    in   1      synchronous, active-high reset
//  wr     in   1      write request; din captured when wr && !full
//  din    in   WIDTH  write data
//  rd     in   1      read request; pops when rd && !empty
//  dout   out  WIDTH  read data, registered, meaningful when valid=1
//  valid  out  1      one-cycle strobe: dout holds the word popped on the previous cycle
//  full   out  1      DEPTH entries stored
//  empty  out  1      zero entries stored
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): wptr=rptr=0, count=0, empty=1, full=0, valid=0, dout=0.
//  - Reset mid-operation discards all contents; valid is 0 on the cycle after reset, whatever rd was.
//  - Pointers ADDR_W bits, wrap modulo DEPTH; count is ADDR_W+1 bits (0..DEPTH).
//  - Write accept: we = wr && !full -> mem[wptr] <= din, wptr++.
//  - Read accept: re = rd && !empty -> dout <= mem[rptr] at that edge, rptr++.
//    valid <= re, so read latency is 1 cycle.
//  - count: +1 on we only, -1 on re only, unchanged on both or neither.
//  - full = (count==DEPTH), empty = (count==0); both are registered or derived from registered count.
//    No combinational path from wr/rd to the flags.
//  - Write while full: dropped, no state change. Read while empty: ignored, valid=0, dout holds.
//  - Simultaneous wr and rd:
//    - not empty, not full: both accepted, count constant.
//    - empty: write only; the new word is not readable until the next cycle (no fall-through).
//    - full: read only; the write is dropped.
//  - dout holds its last value when no read is accepted.
//  - Continuous rd over N stored words yields N consecutive valid cycles, in FIFO order.
// CONFIGURATION
//  - Macro FIFO_ERR_FLAGS_EN defined: adds outputs overflow (1) and underflow (1).
//    overflow is set by wr && full; underflow is set by rd && empty.
//    Both are sticky until rst and both reset to 0.
//  - Macro undefined: the overflow and underflow ports and their logic are absent.
//    Core behaviour is identical either way.
// STRUCTURE
//  - Package fifo_pkg: default WIDTH and DEPTH localparams, the ADDR_W function/localparam,
//    and typedefs addr_t (ADDR_W bits) and count_t (ADDR_W+1 bits).
//  - Sub-module fifo_ram: simple dual-port RAM, DEPTH x WIDTH.
//    Write port: we, waddr, wdata. Registered read port: re, raddr, rdata.
//  - Top level: pointers, count, flags, valid register.
// TESTING
//  - Reset: hold rst 25 cycles, release -> empty=1, full=0, valid=0, dout=0.
//  - Write 2 (0x01,0x02), then 10 (0x03..0x0C); rd 2 -> dout 0x01,0x02.
//    Then rd 10 -> 0x03..0x0C with valid each cycle, then empty=1.
//  - Write 512 (0x0D..0x0C wrapping mod 256) -> full=1 after the 512th.
//    An extra wr is dropped and count stays 512.
//  - After the fill, rd 200; then wr+rd for 100 cycles -> count stays 312, data in order, full=0.
//  - Then rd 312 -> empty=1; rd while empty gives valid=0 and dout unchanged.
//  - Repeat the fill/drain sequence a second time to verify pointer wrap.
//  - Assert rst mid-stream with rd=1 -> next cycle valid=0, empty=1.
//  - With FIFO_ERR_FLAGS_EN: push on full sets overflow; pop on empty sets underflow; both clear on rst.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, address-width helper and pointer/count types for the byte FIFO
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 512;

    function automatic int addr_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

    localparam int ADDR_W = addr_w(DEF_DEPTH);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   count_t;

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port DEPTH x WIDTH RAM with a registered, resettable read port
//   clk   : clock
//   rst   : synchronous active-high reset, clears the read register only
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable,  raddr       : read address
//   rdata : registered read data, holds when re=0
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo: single-clock byte FIFO with registered read data and a one-cycle valid strobe
//   clk, rst      : clock, synchronous active-high reset
//   wr, din       : push request and data, accepted when !full
//   rd            : pop request, accepted when !empty
//   dout, valid   : popped word, valid one cycle after an accepted pop
//   full, empty   : derived from the registered occupancy count
//   overflow/underflow : sticky error flags, present only with FIFO_ERR_FLAGS_EN
module sync_byte_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic             empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          we, re;

    assign full  = count == FULL_CNT;
    assign empty = count == '0;
    assign we    = wr && !full;
    assign re    = rd && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            valid <= 1'b0;
        end else begin
            wptr  <= wptr + AW'(we);
            rptr  <= rptr + AW'(re);
            count <= count + (AW+1)'(we) - (AW+1)'(re);
            valid <= re;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow || (wr && full);
            underflow <= underflow || (rd && empty);
        end
    end
`endif

    fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wptr),
        .wdata (din),
        .re    (re),
        .raddr (rptr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_sync_byte_fifo.sv
// tb_sync_byte_fifo: directed and randomized checks of sync_byte_fifo against a queue model
module tb_sync_byte_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr  = 1'b0;
    logic       rd  = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       valid, full, empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow, underflow;
    logic       exp_ovf, exp_udf;
`endif

    logic [7:0] q [$];
    logic [7:0] exp_dout;
    logic [7:0] nb;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    sync_byte_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .din       (din),
        .rd        (rd),
        .dout      (dout),
        .valid     (valid),
        .full      (full),
        .empty     (empty)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic w, input logic r);
        logic we_m, re_m;
        wr   = w;
        rd   = r;
        din  = nb;
        we_m = w && q.size() < 512;
        re_m = r && q.size() != 0;
`ifdef FIFO_ERR_FLAGS_EN
        exp_ovf = exp_ovf || (w && q.size() == 512);
        exp_udf = exp_udf || (r && q.size() == 0);
`endif
        @(posedge clk);
        if (re_m) exp_dout = q.pop_front();
        if (we_m) begin
            q.push_back(nb);
            nb++;
        end
        #1;
        check("valid", 32'(valid), 32'(re_m));
        check("dout",  32'(dout),  32'(exp_dout));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full",  32'(full),  32'(q.size() == 512));
`ifdef FIFO_ERR_FLAGS_EN
        check("overflow",  32'(overflow),  32'(exp_ovf));
        check("underflow", 32'(underflow), 32'(exp_udf));
`endif
    endtask

    task automatic reset_for(input int n, input logic r);
        rst = 1'b1;
        wr  = 1'b0;
        rd  = r;
        repeat (n) @(posedge clk);
        q.delete();
        exp_dout = 8'h00;
`ifdef FIFO_ERR_FLAGS_EN
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        #1;
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
`else
        #1;
`endif
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_dout",  32'(dout),  32'd0);
        rst = 1'b0;
        rd  = 1'b0;
    endtask

    initial begin
        nb = 8'h01;
        reset_for(25, 1'b0);
        repeat (2)  cyc(1'b1, 1'b0);
        repeat (10) cyc(1'b1, 1'b0);
        repeat (2)  cyc(1'b0, 1'b1);
        repeat (10) cyc(1'b0, 1'b1);
        check("drained_empty", 32'(empty), 32'd1);
        for (int k = 0; k < 2; k++) begin
            repeat (512) cyc(1'b1, 1'b0);
            check("fill_full", 32'(full), 32'd1);
            cyc(1'b1, 1'b0);
            repeat (200) cyc(1'b0, 1'b1);
            repeat (100) cyc(1'b1, 1'b1);
            check("stream_not_full", 32'(full), 32'd0);
            repeat (312) cyc(1'b0, 1'b1);
            check("drain_empty", 32'(empty), 32'd1);
            repeat (3) cyc(1'b0, 1'b1);
            cyc(1'b1, 1'b1);
            cyc(1'b0, 1'b1);
        end
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 1500; i++)
                cyc($urandom_range(0, 99) < (p == 0 ? 70 : p == 1 ? 30 : 50),
                    $urandom_range(0, 99) < (p == 0 ? 30 : p == 1 ? 70 : 50));
        end
        repeat (20) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        reset_for(1, 1'b1);
        cyc(1'b0, 1'b1);
        check("post_rst_empty", 32'(empty), 32'd1);
        repeat (5) cyc(1'b1, 1'b0);
        repeat (6) cyc(1'b0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
